// File: rtl/sensor_st_packetizer.sv
// Packs 16-bit sensor samples pairwise into 32-bit Avalon-ST words, one packet per frame,
// through a small output FIFO; aborted or overflowed packets are always closed with an EOP.
module sensor_st_packetizer #(
    parameter int SAMPLE_W          = 16,
    parameter int SAMPLES_PER_FRAME = 320,
    parameter int FIFO_DEPTH        = 8,
    parameter int CNT_W             = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SAMPLE_W-1:0]   s_data,
    input  logic                  s_valid,
    input  logic                  s_frame_start,
    output logic [2*SAMPLE_W-1:0] st_data,
    output logic                  st_valid,
    input  logic                  st_ready,
    output logic                  st_startofpacket,
    output logic                  st_endofpacket,
    output logic [1:0]            st_empty,
    output logic [CNT_W-1:0]      frame_cnt,
    output logic                  err_overflow,
    input  logic                  err_clr
);
    localparam int WORD_W  = 2 * SAMPLE_W;
    localparam int ENTRY_W = WORD_W + 4;
    localparam int IDX_W   = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_FRAME - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_ABORT} state_t;

    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [SAMPLE_W-1:0]   r_hi;
    logic                  r_wordPushed;
    logic [CNT_W-1:0]      r_frameCnt;
    logic                  r_err;

    logic [ENTRY_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W:0]        r_count;

    state_t                w_nextState;
    logic [IDX_W-1:0]      w_nextIdx;
    logic [IDX_W-1:0]      w_curIdx;
    logic                  w_nextWordPushed;
    logic                  w_take;
    logic                  w_abort;
    logic                  w_wantPush;
    logic [ENTRY_W-1:0]    w_pushEntry;
    logic                  w_loadHi;
    logic                  w_overflow;
    logic                  w_frameDone;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [ENTRY_W-1:0]    w_head;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_push  = w_wantPush && !w_full;
    assign w_pop   = !w_empty && st_ready;

    // Entry layout is {data, sop, eop, empty}; a terminator is an all-zero word with only EOP set.
    always_comb begin
        w_nextState      = r_state;
        w_nextIdx        = r_idx;
        w_nextWordPushed = r_wordPushed;
        w_curIdx         = r_idx;
        w_take           = 1'b0;
        w_abort          = 1'b0;
        w_wantPush       = 1'b0;
        w_pushEntry      = '0;
        w_loadHi         = 1'b0;
        w_overflow       = 1'b0;
        w_frameDone      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (s_valid && s_frame_start) begin
                    w_take   = 1'b1;
                    w_curIdx = '0;
                end
            end
            S_COLLECT: begin
                if (s_valid) begin
                    if (s_frame_start) w_abort = 1'b1;
                    else               w_take  = 1'b1;
                end
            end
            S_ABORT: begin
                if (!w_full) begin
                    w_wantPush       = 1'b1;
                    w_pushEntry      = {{WORD_W{1'b0}}, 1'b0, 1'b1, 2'd0};
                    w_nextState      = S_IDLE;
                    w_nextWordPushed = 1'b0;
                end
            end
            default: w_nextState = S_IDLE;
        endcase

        if (w_take) begin
            if (w_curIdx[0]) begin
                w_wantPush  = 1'b1;
                w_pushEntry = {r_hi, s_data, (w_curIdx == IDX_W'(1)), (w_curIdx == LAST_IDX), 2'd0};
            end else begin
                w_loadHi = 1'b1;
                if (w_curIdx == LAST_IDX) begin
                    w_wantPush  = 1'b1;
                    w_pushEntry = {s_data, {SAMPLE_W{1'b0}}, (w_curIdx == '0), 1'b1, 2'd2};
                end
            end

            if (w_wantPush && w_full) begin
                w_overflow = 1'b1;
                w_abort    = 1'b1;
            end else if (w_curIdx == LAST_IDX) begin
                w_frameDone      = 1'b1;
                w_nextState      = S_IDLE;
                w_nextIdx        = '0;
                w_nextWordPushed = 1'b0;
            end else begin
                w_nextState = S_COLLECT;
                w_nextIdx   = w_curIdx + IDX_W'(1);
                if (w_wantPush) w_nextWordPushed = 1'b1;
            end
        end

        // A packet with nothing in the FIFO yet needs no terminator.
        if (w_abort) begin
            w_nextState      = r_wordPushed ? S_ABORT : S_IDLE;
            w_nextIdx        = '0;
            w_nextWordPushed = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_hi         <= '0;
            r_wordPushed <= 1'b0;
            r_frameCnt   <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_nextState;
            r_idx        <= w_nextIdx;
            r_wordPushed <= w_nextWordPushed;
            if (w_loadHi)    r_hi       <= s_data;
            if (w_frameDone) r_frameCnt <= r_frameCnt + CNT_W'(1);
            r_err        <= (r_err && !err_clr) || w_overflow;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= w_pushEntry;
    end

    // Storage is never reset, so the head is gated to keep outputs at zero while empty.
    assign w_head           = w_empty ? '0 : r_mem[r_rdPtr];
    assign st_valid         = !w_empty;
    assign st_data          = w_head[ENTRY_W-1 -: WORD_W];
    assign st_startofpacket = w_head[3];
    assign st_endofpacket   = w_head[2];
    assign st_empty         = w_head[1:0];
    assign frame_cnt        = r_frameCnt;
    assign err_overflow     = r_err;

endmodule
